signed_calc_solve_v: RTL and testbench

Iterative inverse of the signed calculator f = 6X − 11Y: given a result F and the operand Y, the block recovers X = (F + 11Y) / 6 using a one-bit-per-cycle restoring divider. It flags whether the solution is exact and in range. It sits beside the forward calculator as its checker and decoder, driven by a start/busy/done handshake.

---
 rtl/signed_calc_solve_v_if.sv | 22 ++
 rtl/signed_calc_solve_v.sv | 137 +++++++++++++
 tb/tb_signed_calc_solve_v.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/signed_calc_solve_v_if.sv
// Handshake and data bundle for the iterative inverse of f = 6X - 11Y.
interface signed_calc_solve_v_if;
    logic              i_start;
    logic signed [8:0] i_fs;
    logic signed [4:0] i_bs;
    logic              o_busy;
    logic              o_done;
    logic signed [4:0] o_xs;
    logic signed [3:0] o_rem;
    logic              o_exact;
    logic              o_ovf;

    modport master (
        output i_start, i_fs, i_bs,
        input  o_busy, o_done, o_xs, o_rem, o_exact, o_ovf
    );

    modport slave (
        input  i_start, i_fs, i_bs,
        output o_busy, o_done, o_xs, o_rem, o_exact, o_ovf
    );
endinterface

// File: rtl/signed_calc_solve_v.sv
// Recovers X = (F + 11Y) / 6 with a restoring divider, one quotient bit per cycle.
// Quotient truncates toward zero, remainder takes the dividend's sign, X saturates.
module signed_calc_solve_v (
    input  logic                  i_clk,
    input  logic                  i_rst,
    signed_calc_solve_v_if.slave  io_bus
);
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDiv  = 2'd1,
        StFin  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_sn;
    logic [8:0]        r_dvd;
    logic [8:0]        r_q;
    logic [3:0]        r_rem;
    logic [3:0]        r_cnt;

    logic signed [4:0] r_xs;
    logic signed [3:0] r_rem_s;
    logic              r_exact;
    logic              r_ovf;
    logic              r_done;

    logic [9:0]        w_fs_ext;
    logic [9:0]        w_bs_ext;
    logic [9:0]        w_n;
    logic [8:0]        w_mag;
    logic [4:0]        w_t;
    logic              w_ge;
    logic [3:0]        w_rem_nxt;
    logic              w_ovf;
    logic [4:0]        w_xs;
    logic [3:0]        w_rem_sgn;

    // Dividend n = F + 11Y at 10 bits; magnitude fits 9 bits since |n| <= 432.
    always_comb begin
        w_fs_ext = {io_bus.i_fs[8], io_bus.i_fs};
        w_bs_ext = {{5{io_bus.i_bs[4]}}, io_bus.i_bs};
        w_n      = w_fs_ext + (w_bs_ext << 3) + (w_bs_ext << 1) + w_bs_ext;
        // Low 9 bits are enough for the negation because the magnitude is below 512.
        w_mag    = w_n[9] ? (9'd0 - w_n[8:0]) : w_n[8:0];
    end

    // One restoring step: shift in the next dividend bit and try subtracting 6.
    always_comb begin
        w_t       = {r_rem, r_dvd[8]};
        w_ge      = (w_t >= 5'd6);
        // t <= 11 because r <= 5, so the 4-bit subtract cannot wrap when it is used.
        w_rem_nxt = w_ge ? (w_t[3:0] - 4'd6) : w_t[3:0];
    end

    // Apply the stored sign, then saturate the quotient into the 5-bit X range.
    always_comb begin
        w_ovf     = r_sn ? (r_q > 9'd16) : (r_q > 9'd15);
        w_rem_sgn = r_sn ? (4'd0 - r_rem) : r_rem;
        if (w_ovf) begin
            w_xs = r_sn ? 5'b10000 : 5'b01111;
        end else begin
            w_xs = r_sn ? (5'd0 - r_q[4:0]) : r_q[4:0];
        end
    end

    // Next-state logic: IDLE -> DIV (9 steps) -> FIN -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (io_bus.i_start) w_state_nxt = StDiv;
            StDiv:   if (r_cnt == 4'd8) w_state_nxt = StFin;
            StFin:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: latch operands on start, shift the divider, register results in FIN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sn    <= 1'b0;
            r_dvd   <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_xs    <= '0;
            r_rem_s <= '0;
            r_exact <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (io_bus.i_start) begin
                        r_sn  <= w_n[9];
                        r_dvd <= w_mag;
                        r_q   <= '0;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end
                end
                StDiv: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[7:0], w_ge};
                    r_dvd <= {r_dvd[7:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                end
                StFin: begin
                    r_xs    <= w_xs;
                    r_rem_s <= w_rem_sgn;
                    r_ovf   <= w_ovf;
                    r_exact <= (r_rem == 4'd0) && !w_ovf;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.o_busy  = (r_state != StIdle);
    assign io_bus.o_done  = r_done;
    assign io_bus.o_xs    = r_xs;
    assign io_bus.o_rem   = r_rem_s;
    assign io_bus.o_exact = r_exact;
    assign io_bus.o_ovf   = r_ovf;
endmodule

// File: tb/tb_signed_calc_solve_v.sv
// Randomized bench for signed_calc_solve_v against a cycle-level behavioural model.
module tb_signed_calc_solve_v;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    signed_calc_solve_v_if bus ();

    signed_calc_solve_v dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    typedef struct packed {
        int xs;
        int rem;
        bit exact;
        bit ovf;
    } res_t;

    typedef struct {
        int fs;
        int bs;
        int xs;
        int rem;
        bit exact;
        bit ovf;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division (truncates toward zero), then saturate.
    function automatic res_t solve_ref(input int fs, input int bs);
        res_t r;
        int n, q;
        n       = fs + 11 * bs;
        q       = n / 6;
        r.rem   = n % 6;
        r.ovf   = (q > 15) || (q < -16);
        r.xs    = (q > 15) ? 15 : ((q < -16) ? -16 : q);
        r.exact = (r.rem == 0) && !r.ovf;
        return r;
    endfunction

    // Model: an accepted start produces results ten edges later; starts while busy are dropped.
    bit   m_inflight;
    int   m_steps;
    bit   m_done;
    res_t m_pend;
    res_t m_out;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_inflight <= 1'b0;
            m_steps    <= 0;
            m_done     <= 1'b0;
            m_pend     <= '0;
            m_out      <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_inflight) begin
                m_steps <= m_steps + 1;
                if (m_steps == 9) begin
                    m_inflight <= 1'b0;
                    m_done     <= 1'b1;
                    m_out      <= m_pend;
                end
            end else if (bus.i_start) begin
                m_inflight <= 1'b1;
                m_steps    <= 0;
                m_pend     <= solve_ref(int'(bus.i_fs), int'(bus.i_bs));
            end
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  int'(bus.o_busy),  int'(m_inflight));
            check("done",  int'(bus.o_done),  int'(m_done));
            check("xs",    int'(bus.o_xs),    m_out.xs);
            check("rem",   int'(bus.o_rem),   m_out.rem);
            check("exact", int'(bus.o_exact), int'(m_out.exact));
            check("ovf",   int'(bus.o_ovf),   int'(m_out.ovf));
        end
    end

    // Start one solve from idle (called at posedge+1) and wait, bounded, for o_done.
    task automatic run_one(input int fs, input int bs);
        bit ok;
        bus.i_start = 1'b1;
        bus.i_fs    = 9'(fs);
        bus.i_bs    = 5'(bs);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        ok = 1'b0;
        for (int k = 1; k <= 15 && !ok; k++) begin
            @(posedge clk); #1;
            if (bus.o_done) begin
                ok = 1'b1;
                check("latency", k, 10);
            end
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic check_out(input string tag, input int xs, input int rem, input bit ex,
                             input bit ov);
        check({tag, "_xs"},    int'(bus.o_xs),    xs);
        check({tag, "_rem"},   int'(bus.o_rem),   rem);
        check({tag, "_exact"}, int'(bus.o_exact), int'(ex));
        check({tag, "_ovf"},   int'(bus.o_ovf),   int'(ov));
    endtask

    vec_t vecs [11] = '{
        '{  75,  -3,   7,  0, 1'b1, 1'b0},
        '{-255,  15, -15,  0, 1'b1, 1'b0},
        '{  10,   1,   3,  3, 1'b0, 1'b0},
        '{ -10,  -1,  -3, -3, 1'b0, 1'b0},
        '{ 255,  15,  15,  0, 1'b0, 1'b1},
        '{-256, -16, -16,  0, 1'b0, 1'b1},
        '{   0,   0,   0,  0, 1'b1, 1'b0},
        '{  -1,   0,   0, -1, 1'b0, 1'b0},
        '{  96,   0,  15,  0, 1'b0, 1'b1},
        '{ -96,   0, -16,  0, 1'b1, 1'b0},
        '{-102,   0, -16,  0, 1'b0, 1'b1}
    };

    int corner_fs [5] = '{-256, 255, 0, -1, 1};
    int corner_bs [3] = '{-16, 15, 0};

    initial begin
        res_t r;
        int   last_done;
        int   n_done;
        bit   ok;

        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_fs    = '0;
        bus.i_bs    = '0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Pin the model itself to hand-computed values.
        foreach (vecs[i]) begin
            r = solve_ref(vecs[i].fs, vecs[i].bs);
            check("model_xs",  r.xs,  vecs[i].xs);
            check("model_rem", r.rem, vecs[i].rem);
            check("model_ex",  int'(r.exact), int'(vecs[i].exact));
            check("model_ovf", int'(r.ovf),   int'(vecs[i].ovf));
        end

        // Idle after reset: the compare process flags any spurious o_done.
        repeat (15) @(posedge clk);
        #1;

        // Directed cases against literal expectations.
        foreach (vecs[i]) begin
            run_one(vecs[i].fs, vecs[i].bs);
            check_out("dir", vecs[i].xs, vecs[i].rem, vecs[i].exact, vecs[i].ovf);
            @(posedge clk); #1;
        end

        // Second start at E3 with other operands must be ignored.
        bus.i_start = 1'b1; bus.i_fs = 9'sd10; bus.i_bs = 5'sd1;
        @(posedge clk); #1;                          // E0
        bus.i_start = 1'b0;
        @(posedge clk); #1;                          // E1
        @(posedge clk); #1;                          // E2
        bus.i_start = 1'b1; bus.i_fs = -9'sd10; bus.i_bs = -5'sd1;
        @(posedge clk); #1;                          // E3
        bus.i_start = 1'b0;
        n_done = 0;
        for (int k = 4; k <= 16; k++) begin
            @(posedge clk); #1;
            if (bus.o_done) begin
                n_done++;
                check("ign_latency", k, 10);
            end
        end
        check("ign_dones", n_done, 1);
        check_out("ign", 3, 3, 1'b0, 1'b0);

        // Abort: asynchronous reset mid-cycle after E5 clears outputs immediately.
        bus.i_start = 1'b1; bus.i_fs = 9'sd75; bus.i_bs = -5'sd3;
        @(posedge clk); #1;                          // E0
        bus.i_start = 1'b0;
        repeat (5) @(posedge clk);                   // E5
        #3 rst = 1'b1;
        #1;
        check("abort_busy", int'(bus.o_busy), 0);
        check("abort_done", int'(bus.o_done), 0);
        check_out("abort", 0, 0, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        // Held start: a result every 11 cycles.
        bus.i_start = 1'b1; bus.i_fs = -9'sd255; bus.i_bs = 5'sd15;
        n_done = 0;
        last_done = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (bus.o_done) begin
                if (n_done > 0) check("hold_gap", k - last_done, 11);
                last_done = k;
                n_done++;
            end
        end
        check("hold_dones", n_done, 5);
        bus.i_start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(posedge clk); #1;
            ok = !bus.o_busy;
        end
        if (!ok) check("hold_drain_timeout", 0, 1);
        @(posedge clk); #1;

        // Random phase: operands change every cycle, starts arrive busy or idle, rare resets.
        for (int c = 0; c < 20000; c++) begin
            bus.i_start = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.i_fs = 9'(corner_fs[$urandom_range(0, 4)]);
                bus.i_bs = 5'(corner_bs[$urandom_range(0, 2)]);
            end else begin
                bus.i_fs = 9'($urandom_range(0, 511));
                bus.i_bs = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.i_start = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
